// File: rtl/pipe_sel_pkg.sv
// Shared types for the pipelined N-way select mux.
// The FSM state enum and the fallback input index for illegal selects live here.
package pipe_sel_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int SEL_DEFAULT_IDX = 0;

endpackage

// File: rtl/sel_mux_n.sv
// Combinational N-way word select.
// An out-of-range sel falls back to the default input, so there is no latch and no X.
module sel_mux_n
  import pipe_sel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SELW  = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   data
);

  always_comb begin
    data = in_data[SEL_DEFAULT_IDX*WIDTH +: WIDTH];
    for (int k = 0; k < N; k++) begin
      if (int'(sel) == k) data = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pipe_sel_mux.sv
// Registered N-way select with a valid/ready skid buffer (main + skid).
// Define PIPE_SEL_MUX_ERR_CHK_EN to build the sticky illegal-select flag.
module pipe_sel_mux
  import pipe_sel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pick;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             rdy_q;
  logic             acc;
  logic             xfer;
  logic             load_main;
  logic             load_skid;
  logic             from_skid;

  sel_mux_n #(
    .WIDTH(WIDTH),
    .N    (N),
    .SELW (SELW)
  ) u_mux (
    .in_data(in_data),
    .sel    (sel),
    .data   (pick)
  );

  assign acc       = in_valid & rdy_q;
  assign xfer      = out_valid & out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt = BUSY;
          load_main = 1'b1;
        end
      end
      BUSY: begin
        if (acc && xfer) begin
          load_main = 1'b1;
        end else if (acc) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          state_nxt = BUSY;
          from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready is registered, so it stays low through reset and rises one edge later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)      main_q <= pick;
      else if (from_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= pick;
    end
  end

`ifdef PIPE_SEL_MUX_ERR_CHK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err_q <= 1'b0;
    else if (acc && int'(sel) >= N) err_q <= 1'b1;
  end

  assign sel_err = err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed and scoreboarded checks of pipe_sel_mux (N=3/W=32 and N=5/W=8).
// Expectations for sel_err follow PIPE_SEL_MUX_ERR_CHK_EN.
module tb_pipe_sel_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [95:0] a_in_data;
  logic [1:0]  a_sel;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [31:0] a_out_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic        a_sel_err;

  logic [39:0] b_in_data;
  logic [2:0]  b_sel;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic        b_sel_err;

  int errors = 0;
  int checks = 0;

`ifdef PIPE_SEL_MUX_ERR_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  localparam logic [31:0] WA = 32'h11111111;
  localparam logic [31:0] WB = 32'h22222222;
  localparam logic [31:0] WC = 32'h33333333;

  pipe_sel_mux #(.WIDTH(32), .N(3)) u_a (
    .clk      (clk),
    .rst      (rst),
    .in_data  (a_in_data),
    .sel      (a_sel),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .out_data (a_out_data),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .sel_err  (a_sel_err)
  );

  pipe_sel_mux #(.WIDTH(8), .N(5)) u_b (
    .clk      (clk),
    .rst      (rst),
    .in_data  (b_in_data),
    .sel      (b_sel),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .out_data (b_out_data),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .sel_err  (b_sel_err)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_b(input logic [39:0] d,
                                       input logic [2:0] s);
    if (s < 3'd5) return d[int'(s)*8 +: 8];
    return d[7:0];
  endfunction

  logic [7:0] q[$];
  logic [7:0] w;

  initial begin
    a_in_data   = {WC, WB, WA};
    a_sel       = 2'd0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    b_in_data   = '0;
    b_sel       = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_irdy", a_in_ready, 0);
    check("rst_ovalid", a_out_valid, 0);
    check("rst_odata", a_out_data, 0);
    check("rst_err", a_sel_err, 0);
    rst = 1'b0;
    #4;
    check("irdy_pre_edge", a_in_ready, 0);
    @(negedge clk);
    check("irdy_rise", a_in_ready, 1);
    check("ovalid_idle", a_out_valid, 0);

    // sel=1, one-cycle latency
    a_sel = 2'd1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    check("t1_ovalid", a_out_valid, 1);
    check("t1_odata", a_out_data, WB);
    a_in_valid = 1'b0;
    @(negedge clk);
    check("t1_empty", a_out_valid, 0);

    // backpressure: A,B accepted, C stalls
    a_out_ready = 1'b0; a_sel = 2'd0; a_in_valid = 1'b1;
    @(negedge clk);
    check("t2_ovalid", a_out_valid, 1);
    check("t2_odata_a", a_out_data, WA);
    check("t2_irdy1", a_in_ready, 1);
    a_sel = 2'd1;
    @(negedge clk);
    check("t2_irdy_full", a_in_ready, 0);
    check("t2_odata_a2", a_out_data, WA);
    a_sel = 2'd2;
    @(negedge clk);
    check("t2_irdy_hold", a_in_ready, 0);
    check("t2_odata_hold", a_out_data, WA);
    a_out_ready = 1'b1;
    @(negedge clk);
    check("t2_odata_b", a_out_data, WB);
    check("t2_irdy_back", a_in_ready, 1);
    @(negedge clk);
    check("t2_odata_c", a_out_data, WC);
    check("t2_ovalid_c", a_out_valid, 1);
    a_in_valid = 1'b0;
    @(negedge clk);
    check("t2_empty", a_out_valid, 0);

    // illegal select falls back to input 0
    a_sel = 2'd3; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    check("t3_odata_def", a_out_data, WA);
    check("t3_err", a_sel_err, ERR_EXP);
    a_sel = 2'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_err_hold", a_sel_err, ERR_EXP);
      check("t3_odata_c", a_out_data, WC);
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    check("t3_empty", a_out_valid, 0);

    // async reset while FULL
    a_out_ready = 1'b0; a_sel = 2'd0; a_in_valid = 1'b1;
    @(negedge clk);
    a_sel = 2'd1;
    @(negedge clk);
    check("t4_full_irdy", a_in_ready, 0);
    check("t4_full_ovalid", a_out_valid, 1);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("t4_rst_ovalid", a_out_valid, 0);
    check("t4_rst_odata", a_out_data, 0);
    check("t4_rst_irdy", a_in_ready, 0);
    check("t4_rst_err", a_sel_err, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t4_irdy_pre", a_in_ready, 0);
    @(negedge clk);
    check("t4_irdy_rise", a_in_ready, 1);
    check("t4_ovalid", a_out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_no_stale", a_out_valid, 0);
    end

    // random traffic through the N=5, W=8 instance
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      check("b_ovalid", b_out_valid, q.size() != 0);
      check("b_irdy", b_in_ready, q.size() < 2);
      b_in_data   = {8'($urandom), 32'($urandom)};
      b_sel       = 3'($urandom_range(0, 7));
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      if (b_out_valid && b_out_ready) begin
        if (q.size() == 0) begin
          check("b_extra_word", 1, 0);
        end else begin
          w = q.pop_front();
          check("b_data", b_out_data, w);
        end
      end
      if (b_in_valid && b_in_ready) q.push_back(exp_b(b_in_data, b_sel));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      if (b_out_valid) begin
        if (q.size() == 0) begin
          check("b_drain_extra", 1, 0);
        end else begin
          w = q.pop_front();
          check("b_drain_data", b_out_data, w);
        end
      end
    end
    @(negedge clk);
    check("b_lost_words", q.size(), 0);
    check("b_final_ovalid", b_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_sel_mux.md
PIPE_SEL_MUX -- requirements
Module: pipe_sel_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width per input in bits (legal 1..64).
REQ-002 The block SHALL have parameter N, default 3, meaning the number of selectable inputs (legal 2..16).
REQ-003 The block SHALL have parameter SELW, default $clog2(N), meaning the select width, derived and not overridden.
REQ-004 The block SHALL have port clk  in  1  the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have port in_data  in  N*WIDTH  packed inputs, with input k occupying bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port sel  in  SELW  the input index, sampled with in_data.
REQ-008 The block SHALL have port in_valid  in  1  meaning the upstream offers in_data/sel this cycle.
REQ-009 The block SHALL have port in_ready  out  1  driven directly from a register, meaning the block accepts this cycle.
REQ-010 The block SHALL have port out_data  out  WIDTH  the selected, registered word.
REQ-011 The block SHALL have port out_valid  out  1  meaning out_data is valid.
REQ-012 The block SHALL have port out_ready  in  1  meaning downstream takes out_data this cycle.
REQ-013 The block SHALL have port sel_err  out  1  a sticky illegal-select flag (see Configuration).

Function
REQ-014 Accept SHALL occur when in_valid and in_ready are both 1; a transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 On accept, the word selected by sel SHALL be captured; for sel>=N the captured word SHALL be input 0, with no latch and no X.
REQ-016 Latency SHALL be 1 cycle: a word accepted at edge t SHALL be on out_data with out_valid=1 after edge t when the block was EMPTY.
REQ-017 The state machine SHALL have states EMPTY (0 words held), BUSY (main register full) and FULL (main and skid registers full).
REQ-018 In EMPTY, an accept SHALL move the state to BUSY, with the word in main.
REQ-019 In BUSY, an accept with a transfer SHALL keep the state BUSY with main replaced by the new word.
REQ-020 In BUSY, an accept without a transfer SHALL move the state to FULL, with the word in skid.
REQ-021 In BUSY, a transfer without an accept SHALL move the state to EMPTY.
REQ-022 In FULL, a transfer SHALL load main from skid and move the state to BUSY; in FULL, in_ready SHALL be 0, so no accept occurs.
REQ-023 in_ready SHALL be 1 exactly when the state is not FULL; out_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-024 Order SHALL be preserved, with no word dropped or duplicated under any pattern of in_valid/out_ready.
REQ-025 out_data SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-026 While rst=1, the state SHALL be EMPTY, in_ready=0, out_valid=0, out_data=0 and sel_err=0, with main and skid cleared.
REQ-027 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-028 Reset mid-operation SHALL discard held words without emitting them.

Configuration
REQ-029 With macro PIPE_SEL_MUX_ERR_CHK_EN defined, sel_err SHALL set on any accept with sel>=N and clear only on reset.
REQ-030 Without PIPE_SEL_MUX_ERR_CHK_EN, sel_err SHALL be constant 0 and no check logic SHALL be generated.
REQ-031 Datapath behaviour SHALL be identical with and without PIPE_SEL_MUX_ERR_CHK_EN.

Structure
REQ-032 Shared package pipe_sel_pkg SHALL hold the state enum (EMPTY/BUSY/FULL) and the constant SEL_DEFAULT_IDX=0.
REQ-033 Selection SHALL be one combinational sub-module, sel_mux_n (parametrised WIDTH, N, with a default arm), instantiated once ahead of the registers.
REQ-034 The handshake/skid registers SHALL reside in pipe_sel_mux.

Verification
REQ-035 The bench SHALL cover: N=3, WIDTH=32, out_ready=1, in_data={C,B,A} = {0x33333333,0x22222222,0x11111111}, sel=1 -> 0x22222222 on out_data 1 cycle later.
REQ-036 The bench SHALL cover: out_ready=0 while 3 words with sel 0,1,2 are offered -> 2 accepted, in_ready=0 after the 2nd; then out_ready=1 -> words emerge in order A,B, then C accepted.
REQ-037 The bench SHALL cover: sel=3 with N=3 -> out_data=input0; with PIPE_SEL_MUX_ERR_CHK_EN, sel_err=1 and held across 10 legal cycles; without the macro, sel_err=0.
REQ-038 The bench SHALL cover: state FULL, then rst pulsed for 1 cycle asynchronously mid-cycle -> out_valid=0 immediately, in_ready=1 one edge after release, no stale word emitted.
REQ-039 The bench SHALL cover: 1000 cycles of random in_valid/out_ready with N=5, WIDTH=8 -> the scoreboard matches every word, in order, with zero loss.
